fft_iter_agu: RTL

Address-generation and sequencing unit for the in-place, radix-2 decimation-in-time iterative FFT. It walks every stage and every butterfly of an N = 2^N_LOG2 point transform. For each butterfly it issues the A/B operand read addresses and the twiddle ROM index that feed `complex_butterfly_simple`. After a fixed pipeline delay it issues the matching write-back addresses for the X/Y results. It sits between the sample-buffer RAM / twiddle ROM and the butterfly, and owns the start/done handshake of the FFT core.

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_delay_line.sv | 29 ++
 rtl/fft_iter_agu.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and defaults for the iterative radix-2 FFT address generator.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } agu_state_e;

  localparam int unsigned FFT_N_LOG2_DEF = 8;
  localparam int unsigned FFT_LAT_DEF    = 2;
  localparam int unsigned FFT_STAGE_W    = 4;

endpackage

// File: rtl/fft_delay_line.sv
// LAT-deep register chain for the write-back path; synchronous clear, hold when i_en is low.
module fft_delay_line
  import fft_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = FFT_LAT_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] pipe_q [DEPTH];

  // Shift the chain one place per enabled cycle; reset empties every slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else if (i_en) begin
      pipe_q[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign o_q = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_iter_agu.sv
// Address generator / sequencer for an in-place radix-2 DIT FFT.
// Optional feature: define FFT_AGU_STALL_EN to add the i_stall hold input.
module fft_iter_agu
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2 = FFT_N_LOG2_DEF,
  parameter int unsigned LAT    = FFT_LAT_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
`ifdef FFT_AGU_STALL_EN
  input  logic                   i_stall,
`endif
  output logic                   o_busy,
  output logic                   o_done,
  output logic [FFT_STAGE_W-1:0] o_stage,
  output logic                   o_rd_en,
  output logic [N_LOG2-1:0]      o_rd_addr_a,
  output logic [N_LOG2-1:0]      o_rd_addr_b,
  output logic [N_LOG2-2:0]      o_tw_addr,
  output logic                   o_wr_en,
  output logic [N_LOG2-1:0]      o_wr_addr_a,
  output logic [N_LOG2-1:0]      o_wr_addr_b
);

  localparam int unsigned KW = N_LOG2 - 1;
  localparam int unsigned DW = 1 + 2 * N_LOG2;
  localparam logic [KW-1:0]          K_LAST = '1;
  localparam logic [FFT_STAGE_W-1:0] S_LAST = FFT_STAGE_W'(N_LOG2 - 1);
  localparam logic [FFT_STAGE_W-1:0] KW_S   = FFT_STAGE_W'(KW);
  localparam logic [3:0]             D_LAST = 4'(LAT - 1);

  agu_state_e             state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [FFT_STAGE_W-1:0] s_q, s_d;
  logic [3:0]             dcnt_q, dcnt_d;
  logic                   stall;
  logic                   run;

`ifdef FFT_AGU_STALL_EN
  assign stall = i_stall;
`else
  assign stall = 1'b0;
`endif

  // Sequencer registers: state, butterfly counter, stage, drain counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      s_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      s_q     <= s_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state: walk k across a stage, drain LAT cycles, advance s, finish.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    dcnt_d  = dcnt_q;
    if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d = ST_RUN;
            k_d     = '0;
            s_d     = '0;
          end
        end
        ST_RUN: begin
          k_d = k_q + 1'b1;
          if (k_q == K_LAST) begin
            state_d = ST_DRAIN;
            dcnt_d  = '0;
          end
        end
        ST_DRAIN: begin
          if (dcnt_q == D_LAST) begin
            if (s_q == S_LAST) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
              s_d     = s_q + 1'b1;
              k_d     = '0;
            end
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          s_d     = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ((k >> s) << (s+1)) | p is formed by splitting k with a low-bit mask and
  // shifting the upper part up by one, which avoids a variable double shift.
  logic [KW-1:0]          mask_k, p_k, hi_k, tw_k;
  logic [N_LOG2-1:0]      addr_a, addr_b, half;
  logic [FFT_STAGE_W-1:0] tw_sh;

  assign mask_k = ~({KW{1'b1}} << s_q);
  assign p_k    = k_q & mask_k;
  assign hi_k   = k_q & ~mask_k;
  assign addr_a = {hi_k, 1'b0} | {1'b0, p_k};
  assign half   = {1'b0, mask_k} + N_LOG2'(1);
  assign addr_b = addr_a | half;
  assign tw_sh  = KW_S - s_q;
  assign tw_k   = p_k << tw_sh;

  assign run         = (state_q == ST_RUN);
  assign o_rd_en     = run & ~stall;
  assign o_rd_addr_a = run ? addr_a : '0;
  assign o_rd_addr_b = run ? addr_b : '0;
  assign o_tw_addr   = run ? tw_k : '0;
  assign o_stage     = s_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);

  logic [DW-1:0] wb;

  fft_delay_line #(
    .W     (DW),
    .DEPTH (LAT)
  ) u_wb_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (~stall),
    .i_d   ({run, o_rd_addr_a, o_rd_addr_b}),
    .o_q   (wb)
  );

  assign o_wr_en     = wb[DW-1] & ~stall;
  assign o_wr_addr_a = wb[2*N_LOG2-1:N_LOG2];
  assign o_wr_addr_b = wb[N_LOG2-1:0];

endmodule
